sobel_stream_control: RTL and testbench

Raster-scan Sobel edge-detection controller for a single-port grayscale frame store. Issues one read address per pixel, accepts the returned gray pixel, maintains a 3x3 window using two line buffers, and emits one Sobel magnitude pixel per input pixel with a one-cycle completion strobe. Sits between the frame RAM and the output frame writer. Processes one pixel per fixed 10-cycle slot.

---
 rtl/sobel_stream_control.sv | 174 +++++++++++++++++
 tb/tb_sobel_stream_control.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_control.sv
// sobel_stream_control
//   Raster-scan Sobel edge-detection controller for a single-port grayscale
//   frame store. Each pixel occupies a fixed 10-cycle slot (s = 0..9):
//     s=2 window shifts in {linebuf0[col], linebuf1[col], input pixel}
//     s=3 line buffers rotate
//     s=4 Gx/Gy registered, s=5 |Gx|/|Gy| registered
//     s=6 output registered, s=7 completion strobe high
//     s=9 address/row/col advance, next slot starts or block idles
//   Optional build macro: SOBEL_THRESHOLD_EN (binarize the magnitude against
//   THRESHOLD); undefined gives the saturated magnitude.
// Ports
//   sobel_clk_i        clock, rising edge
//   nreset_i           asynchronous active-low reset
//   prep_allowed       run enable, sampled at slot boundaries
//   input_px_gray_i    gray pixel at read_addr_o, valid from slot cycle 2
//   output_px_sobel_o  registered Sobel result of the current slot's pixel
//   pixel_completed_o  one-cycle strobe, output newly valid
//   read_addr_o        linear address of the pixel being fetched
module sobel_stream_control #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int ADDR_BITS   = 17,
    parameter int THRESHOLD   = 128
) (
    input  logic                   sobel_clk_i,
    input  logic                   nreset_i,
    input  logic                   prep_allowed,
    input  logic [PIXEL_WIDTH-1:0] input_px_gray_i,
    output logic [PIXEL_WIDTH-1:0] output_px_sobel_o,
    output logic                   pixel_completed_o,
    output logic [ADDR_BITS-1:0]   read_addr_o
);

    localparam int RAM_DEPTH = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_BITS  = $clog2(IMG_WIDTH);
    localparam int ROW_BITS  = $clog2(IMG_HEIGHT);
    localparam int GW        = PIXEL_WIDTH + 3;   // signed gradient width
    localparam int AW        = PIXEL_WIDTH + 2;   // gradient magnitude width

    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(RAM_DEPTH - 1);
    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [COL_BITS-1:0]  COL_TWO   = COL_BITS'(2);
    localparam logic [ROW_BITS-1:0]  ROW_TWO   = ROW_BITS'(2);
    localparam logic [GW-1:0]        PX_MAX    = GW'((1 << PIXEL_WIDTH) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [3:0]             slot;
    logic [COL_BITS-1:0]    col;
    logic [ROW_BITS-1:0]    row;
    logic [PIXEL_WIDTH-1:0] p [3][3];
    logic [PIXEL_WIDTH-1:0] linebuf0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] linebuf1 [IMG_WIDTH];
    logic signed [GW-1:0]   gx, gy;
    logic [AW-1:0]          ax, ay;

    logic signed [GW-1:0]   gx_c, gy_c;
    logic [GW-1:0]          ngx_c, ngy_c;
    logic [AW-1:0]          ax_c, ay_c;
    logic [GW-1:0]          mag_c;
    logic [PIXEL_WIDTH-1:0] px_c;

    function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    always_comb begin
        gx_c  = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
              - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
        gy_c  = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
              - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
        ngx_c = -gx;
        ngy_c = -gy;
        // |G| never exceeds 4*(2^PIXEL_WIDTH-1), so AW bits always hold it
        ax_c  = gx[GW-1] ? ngx_c[AW-1:0] : gx[AW-1:0];
        ay_c  = gy[GW-1] ? ngy_c[AW-1:0] : gy[AW-1:0];
        mag_c = {1'b0, ax} + {1'b0, ay};
`ifdef SOBEL_THRESHOLD_EN
        px_c  = (mag_c >= GW'(THRESHOLD)) ? '1 : '0;
`else
        px_c  = (mag_c > PX_MAX) ? '1 : mag_c[PIXEL_WIDTH-1:0];
`endif
        // window spans a frame edge or a previous row/frame: mask to zero
        if (row < ROW_TWO || col < COL_TWO) begin
            px_c = '0;
        end
    end

    always_ff @(posedge sobel_clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state             <= IDLE;
            slot              <= '0;
            col               <= '0;
            row               <= '0;
            read_addr_o       <= '0;
            output_px_sobel_o <= '0;
            pixel_completed_o <= 1'b0;
            gx                <= '0;
            gy                <= '0;
            ax                <= '0;
            ay                <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    p[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    pixel_completed_o <= 1'b0;
                    if (prep_allowed) begin
                        state <= RUN;
                        slot  <= '0;
                    end
                end
                RUN: begin
                    pixel_completed_o <= (slot == 4'd6);
                    slot              <= (slot == 4'd9) ? 4'd0 : slot + 4'd1;
                    case (slot)
                        4'd2: begin
                            for (int unsigned r = 0; r < 3; r++) begin
                                p[r][0] <= p[r][1];
                                p[r][1] <= p[r][2];
                            end
                            p[0][2] <= linebuf0[col];
                            p[1][2] <= linebuf1[col];
                            p[2][2] <= input_px_gray_i;
                        end
                        4'd4: begin
                            gx <= gx_c;
                            gy <= gy_c;
                        end
                        4'd5: begin
                            ax <= ax_c;
                            ay <= ay_c;
                        end
                        4'd6: output_px_sobel_o <= px_c;
                        4'd9: begin
                            if (read_addr_o == ADDR_LAST) begin
                                read_addr_o <= '0;
                                col         <= '0;
                                row         <= '0;
                            end else begin
                                read_addr_o <= read_addr_o + 1'b1;
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                            if (!prep_allowed) begin
                                state <= IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line buffers carry no reset; stale rows are masked by the border rule.
    always_ff @(posedge sobel_clk_i) begin
        if (state == RUN && slot == 4'd3) begin
            linebuf0[col] <= linebuf1[col];
            linebuf1[col] <= input_px_gray_i;
        end
    end

endmodule

// File: tb/tb_sobel_stream_control.sv
module tb_sobel_stream_control;

    localparam int PW    = 8;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int AB    = 6;
    localparam int DEPTH = W * H;

    logic          clk = 1'b0;
    logic          nreset;
    logic          prep;
    logic [PW-1:0] gray;
    logic [PW-1:0] px_out;
    logic          strobe;
    logic [AB-1:0] addr;

    logic [PW-1:0] img [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            exp_addr = 0;
    logic [PW-1:0] held;

    always #5 clk = ~clk;

    // frame RAM model: zero-latency read of the current image
    assign gray = (addr < AB'(DEPTH)) ? img[addr] : '0;

    sobel_stream_control #(
        .PIXEL_WIDTH (PW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .ADDR_BITS   (AB),
        .THRESHOLD   (128)
    ) dut (
        .sobel_clk_i       (clk),
        .nreset_i          (nreset),
        .prep_allowed      (prep),
        .input_px_gray_i   (gray),
        .output_px_sobel_o (px_out),
        .pixel_completed_o (strobe),
        .read_addr_o       (addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sobel of the 3x3 neighbourhood whose bottom-right is pixel a
    function automatic logic [PW-1:0] model_px(input int a);
        int r, c, gx, gy, v, mag;
        r = a / W;
        c = a % W;
        if (r < 2 || c < 2) return '0;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v  = int'(img[(r - 2 + i) * W + (c - 2 + j)]);
                gx += (j - 1) * ((i == 1) ? 2 : 1) * v;
                gy += (i - 1) * ((j == 1) ? 2 : 1) * v;
            end
        end
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= 128) ? 8'hFF : 8'h00;
`else
        return (mag > 255) ? 8'hFF : PW'(mag);
`endif
    endfunction

    task automatic fill_image(input int kind);
        int r, c;
        for (int a = 0; a < DEPTH; a++) begin
            r = a / W;
            c = a % W;
            case (kind)
                1:       img[a] = 8'h80;
                2:       img[a] = (c < W / 2) ? 8'h00 : 8'hFF;
                3:       img[a] = (r < H / 2) ? 8'h00 : 8'hFF;
                4:       img[a] = PW'(c);
                5:       img[a] = (c * 64 > 255) ? 8'hFF : PW'(c * 64);
                default: img[a] = PW'($urandom_range(0, 255));
            endcase
        end
    endtask

    // wait for the next strobe; gap = expected negedge count since the call (0 = unchecked)
    task automatic do_pixel(input int gap);
        int  n;
        bit  got;
        logic [PW-1:0] exp_px;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (strobe) begin
                got = 1'b1;
                break;
            end
        end
        check("strobe_seen", 32'(got), 32'd1);
        exp_px = model_px(exp_addr);
        check("read_addr", 32'(addr), 32'(exp_addr));
        check("sobel_px", 32'(px_out), 32'(exp_px));
        if (gap != 0) check("strobe_gap", 32'(n), 32'(gap));
        held     = exp_px;
        exp_addr = (exp_addr + 1) % DEPTH;
    endtask

    task automatic run_pixels(input int n);
        for (int i = 0; i < n; i++) do_pixel(10);
    endtask

    initial begin
        nreset = 1'b0;
        prep   = 1'b0;
        fill_image(0);
        repeat (3) @(negedge clk);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_px", 32'(px_out), 32'd0);
        check("reset_strobe", 32'(strobe), 32'd0);
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_addr", 32'(addr), 32'd0);
            check("idle_strobe", 32'(strobe), 32'd0);
        end

        // frames: random, constant, vertical step, horizontal step, ramp, steep ramp
        prep = 1'b1;
        do_pixel(8);
        run_pixels(DEPTH - 1);
        fill_image(1); run_pixels(DEPTH);
        fill_image(2); run_pixels(DEPTH);
        fill_image(3); run_pixels(DEPTH);
        fill_image(4); run_pixels(DEPTH);
        fill_image(5); run_pixels(DEPTH);

        // gating: drop prep during s=4 of pixel 20
        fill_image(0);
        run_pixels(20);
        repeat (7) @(negedge clk);
        prep = 1'b0;
        do_pixel(3);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_addr", 32'(addr), 32'd21);
            check("hold_strobe", 32'(strobe), 32'd0);
            check("hold_px", 32'(px_out), 32'(held));
        end
        prep = 1'b1;
        do_pixel(8);
        run_pixels(DEPTH - 22);

        // asynchronous reset in the middle of a slot
        fill_image(0);
        run_pixels(5);
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("async_rst_addr", 32'(addr), 32'd0);
        check("async_rst_px", 32'(px_out), 32'd0);
        check("async_rst_strobe", 32'(strobe), 32'd0);
        @(negedge clk);
        nreset   = 1'b1;
        exp_addr = 0;
        do_pixel(8);
        run_pixels(DEPTH - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
